// File: rtl/sll_multicycle_pkg.sv
// sll_multicycle_pkg: shifter constants and FSM encoding shared with the right-shift units
package sll_multicycle_pkg;
    localparam int DATA_W  = 32;
    localparam int SHAMT_W = 5;
    localparam int STEP_N  = 5;
    localparam int STEP_W  = 3;
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/sll_multicycle_if.sv
// sll_multicycle_if: start/operand/result bundle of the multicycle left shifter
interface sll_multicycle_if;
    import sll_multicycle_pkg::*;
    logic               ctrl_start;
    logic [DATA_W-1:0]  data_operandA;
    logic [SHAMT_W-1:0] ctrl_shiftamt;
    logic [DATA_W-1:0]  data_result;
    logic               data_resultRDY;
    logic               ctrl_overflow;
    logic               busy;
    modport master (
        output ctrl_start, data_operandA, ctrl_shiftamt,
        input  data_result, data_resultRDY, ctrl_overflow, busy
    );
    modport slave (
        input  ctrl_start, data_operandA, ctrl_shiftamt,
        output data_result, data_resultRDY, ctrl_overflow, busy
    );
endinterface

// File: rtl/sll_multicycle_step.sv
// sll_step: one conditional logical left shift by 2^k, flagging any 1 bits pushed past the MSB
module sll_step
    import sll_multicycle_pkg::*;
(
    input  logic [DATA_W-1:0] value,
    input  logic              enable,
    input  logic [STEP_W-1:0] k,
    output logic [DATA_W-1:0] shifted,
    output logic              lost
);
    logic [SHAMT_W:0]  amt;
    logic [DATA_W-1:0] top_mask;
    assign amt      = (SHAMT_W + 1)'(1) << k;
    assign top_mask = ~({DATA_W{1'b1}} >> amt);
    assign shifted  = enable ? value << amt : value;
    assign lost     = enable & |(value & top_mask);
endmodule

// File: rtl/sll_multicycle.sv
// sll_multicycle: 32-bit logical left shifter, one binary-weighted step per cycle,
// fixed 5-cycle latency from accepted start to the data_resultRDY pulse.
module sll_multicycle #(
    parameter int DATA_W  = sll_multicycle_pkg::DATA_W,
    parameter int SHAMT_W = sll_multicycle_pkg::SHAMT_W
) (
    input  logic              clock,
    input  logic              reset_n,
    sll_multicycle_if.slave   bus
);
    import sll_multicycle_pkg::state_t;
    import sll_multicycle_pkg::IDLE;
    import sll_multicycle_pkg::SHIFT;
    import sll_multicycle_pkg::DONE;
    import sll_multicycle_pkg::STEP_N;
    import sll_multicycle_pkg::STEP_W;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  work_q, result_q, shifted;
    logic [SHAMT_W-1:0] shamt_q;
    logic [STEP_W-1:0]  step_q;
    logic               ovf_work_q, ovf_q, lost, accept, last;

    assign accept = (state_q != SHIFT) & bus.ctrl_start;
    assign last   = step_q == STEP_W'(STEP_N - 1);

    sll_step u_step (
        .value  (work_q),
        .enable (shamt_q[step_q]),
        .k      (step_q),
        .shifted(shifted),
        .lost   (lost)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = accept ? SHIFT : (state_q == SHIFT) ? (last ? DONE : SHIFT) : IDLE;
    end

    // work register iterates privately; the visible result only changes on the final step
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            work_q     <= '0;
            shamt_q    <= '0;
            step_q     <= '0;
            ovf_work_q <= 1'b0;
            result_q   <= '0;
            ovf_q      <= 1'b0;
        end else if (accept) begin
            work_q     <= bus.data_operandA;
            shamt_q    <= bus.ctrl_shiftamt;
            step_q     <= '0;
            ovf_work_q <= 1'b0;
        end else if (state_q == SHIFT) begin
            work_q     <= shifted;
            ovf_work_q <= ovf_work_q | lost;
            step_q     <= step_q + 1'b1;
            if (last) begin
                result_q <= shifted;
                ovf_q    <= ovf_work_q | lost;
            end
        end
    end

    assign bus.data_result    = result_q;
    assign bus.ctrl_overflow  = ovf_q;
    assign bus.data_resultRDY = state_q == DONE;
    assign bus.busy           = state_q == SHIFT;
endmodule
